// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit producing the HI/LO pair, one result bit per cycle.
// Optional feature: define MDU_EARLY_EXIT_EN to let multiplies finish once the multiplier is exhausted.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     divisor;

    logic                 is_signed;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH-1:0]     rem_diff;
    logic                 fits;
    logic                 early_exit;
    logic [2*WIDTH-1:0]   mul_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Signed ops run on magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_abs     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    assign rem_shift = {rem, quo[WIDTH-1]};
    assign fits      = rem_shift >= {1'b0, divisor};
    assign rem_diff  = rem_shift[WIDTH-1:0] - divisor;

    assign mul_fix   = neg_res ? -acc : acc;
    assign quo_fix   = neg_res ? -quo : quo;
    assign rem_fix   = neg_rem ? -rem : rem;

`ifdef MDU_EARLY_EXIT_EN
    assign early_exit = ~is_div & (mplier == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Multiply accumulates a left-shifting multiplicand, so stopping early leaves the product exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem <= is_signed & op_a[WIDTH-1];
                        acc     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, a_abs};
                        mplier  <= b_abs;
                        rem     <= '0;
                        quo     <= a_abs;
                        divisor <= b_abs;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (early_exit) begin
                        state <= FINISH;
                    end else begin
                        if (is_div) begin
                            rem <= fits ? rem_diff : rem_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], fits};
                        end else begin
                            if (mplier[0]) begin
                                acc <= acc + mcand;
                            end
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end
                        count <= count + CW'(1);
                        if (count == CW'(WIDTH - 1)) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= mul_fix[2*WIDTH-1:WIDTH];
                        lo <= mul_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, hand-written corner sequences and
// randomized operations compared against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference results straight from integer arithmetic; divide by zero follows the documented values.
    function automatic logic [63:0] refModel(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Cycles from the START edge to the DONE edge.
    function automatic int expLatency(logic [1:0] o, logic [31:0] b);
        int lat = WIDTH + 1;
`ifdef MDU_EARLY_EXIT_EN
        logic [31:0] mag;
        if (!o[1]) begin
            mag = (o == 2'b00 && b[31]) ? -b : b;
            if (mag == 32'd0) begin
                lat = 2;
            end else begin
                for (int i = 0; i < 32; i++) begin
                    if (mag[i]) lat = i + 3;
                end
                if (lat > WIDTH + 1) lat = WIDTH + 1;
            end
        end
`endif
        return lat;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
            check("busy_in_flight", {31'b0, busy}, 32'd1);
            if (lat >= 100) begin
                check("done_timeout", {31'b0, done}, 32'd1);
                break;
            end
        end
    endtask

    task automatic checkOutput(string name, int lat, int exp_lat, logic [31:0] eh, logic [31:0] el);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic runOp(string name, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                         logic [31:0] eh, logic [31:0] el);
        int lat;
        applyStimulus(o, a, b);
        waitDone(lat);
        checkOutput(name, lat, expLatency(o, b), eh, el);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({name, "_hi_hold"}, hi, eh);
        check({name, "_lo_hold"}, lo, el);
    endtask

    initial begin
        vec_t        vecs[$];
        int          lat;
        int          lat2;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp64;

        vecs.push_back('{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"mult_neg",    2'b00, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6});
        vecs.push_back('{"div_neg",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"divu_zero",   2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF});
        vecs.push_back('{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000});
        vecs.push_back('{"divu_10_3",   2'b11, 32'd10,       32'd3,        32'd1,        32'd3});
        vecs.push_back('{"multu_3_1",   2'b01, 32'd3,        32'd1,        32'd0,        32'd3});
        vecs.push_back('{"multu_3_0",   2'b01, 32'd3,        32'd0,        32'd0,        32'd0});
        vecs.push_back('{"div_neg_z",   2'b10, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'd1});
        vecs.push_back('{"div_pos_neg", 2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
        vecs.push_back('{"mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // START while busy is ignored, operand changes too; a START in the DONE cycle is taken.
        applyStimulus(2'b11, 32'd10, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
            check("busy_early", {31'b0, busy}, 32'd1);
        end
        applyStimulus(2'b01, 32'd2, 32'd2);
        waitDone(lat);
        checkOutput("ignore_start", lat + 10, expLatency(2'b11, 32'd3), 32'd1, 32'd3);
        applyStimulus(2'b01, 32'd2, 32'd2);
        waitDone(lat2);
        checkOutput("back_to_back", lat2, expLatency(2'b01, 32'd2), 32'd0, 32'd4);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation clears HI/LO at once and suppresses DONE.
        runOp("prior", 2'b01, 32'h12345678, 32'h10, 32'd1, 32'h23456780);
        applyStimulus(2'b01, 32'd5, 32'd5);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        #3 rst_n = 1'b0;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {31'b0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp("after_reset", 2'b01, 32'd5, 32'd5, 32'd0, 32'd25);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                3:       begin rb = $urandom; ra = 32'h80000000; end
                default: rb = $urandom;
            endcase
            exp64 = refModel(ro, ra, rb);
            runOp("random", ro, ra, rb, exp64[63:32], exp64[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
